// File: rtl/rv32i_types.sv
// Shared RV32I memory-stage types: load/store funct3 encodings, the
// load/store unit state enum and the access-size helper.
package rv32i_types;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        MAU_IDLE  = 2'd0,
        MAU_BEAT0 = 2'd1,
        MAU_BEAT1 = 2'd2,
        MAU_RESP  = 2'd3
    } mau_state_t;

    // Access size in bytes encoded by funct3[1:0] (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering for the load/store unit: byte-enable generation,
// store data shift/split across two beats, and load merge with extension.
module mau_lane_align
    import rv32i_types::*;
#(
    parameter  int DATA_W = 32,
    localparam int BYTES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [2:0]        i_funct3,
    input  logic [OFF_W-1:0]  i_off,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_beat0,
    input  logic [DATA_W-1:0] i_beat1,
    output logic [BYTES-1:0]  o_be_lo,
    output logic [BYTES-1:0]  o_be_hi,
    output logic [DATA_W-1:0] o_wd_lo,
    output logic [DATA_W-1:0] o_wd_hi,
    output logic [DATA_W-1:0] o_rdata
);

    logic [3:0]          w_size;
    logic [8:0]          w_size_mask;
    logic [2*BYTES-1:0]  w_mask;
    logic [2*DATA_W-1:0] w_wd_shift;
    logic [2*DATA_W-1:0] w_wd_masked;
    logic [DATA_W-1:0]   w_merged;
    logic                w_sign;
    int                  w_nbits;

    assign w_size = size_bytes(i_funct3);

    // Byte mask over two beats: size ones shifted up to the start offset.
    always_comb begin
        w_size_mask = (9'd1 << w_size) - 9'd1;
        w_mask      = (2*BYTES)'(w_size_mask) << i_off;
    end

    // Store data shifted into its lanes; bytes outside the mask are forced to zero.
    always_comb begin
        w_wd_shift = {{DATA_W{1'b0}}, i_wdata} << {i_off, 3'b000};
        for (int b = 0; b < 2*BYTES; b++) begin
            w_wd_masked[8*b +: 8] = w_mask[b] ? w_wd_shift[8*b +: 8] : 8'h00;
        end
    end

    assign o_be_lo = w_mask[BYTES-1:0];
    assign o_be_hi = w_mask[2*BYTES-1:BYTES];
    assign o_wd_lo = w_wd_masked[DATA_W-1:0];
    assign o_wd_hi = w_wd_masked[2*DATA_W-1:DATA_W];

    // Load merge: beat0 bytes from the offset upward, then beat1 bytes from lane 0.
    always_comb begin
        w_merged = DATA_W'({i_beat1, i_beat0} >> {i_off, 3'b000});
    end

    // Truncate to the access size, then sign- or zero-extend.
    always_comb begin
        w_nbits = 8 * int'(w_size);
        if (w_nbits > DATA_W) begin
            w_nbits = DATA_W;
        end
        case (i_funct3[1:0])
            2'd0:    w_sign = w_merged[7];
            2'd1:    w_sign = w_merged[15];
            2'd2:    w_sign = w_merged[31];
            default: w_sign = w_merged[DATA_W-1];
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            o_rdata[i] = (i < w_nbits) ? w_merged[i] : (w_sign & ~i_funct3[2]);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Handshaked load/store unit between the MEM stage and the data memory port.
// Accepts one request at a time, splits boundary-crossing accesses into two
// beats, and returns extended load data with a one-cycle completion pulse.
module mem_access_unit
    import rv32i_types::*;
#(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_byte_enable,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_resp
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    mau_state_t        r_state;
    mau_state_t        w_next;
    logic              r_read;
    logic              r_write;
    logic              r_err;
    logic              r_cross;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata;

    logic [3:0]        w_req_size;
    logic [OFF_W-1:0]  w_req_off;
    logic              w_req_cross;
    logic              w_req_illegal;
    logic              w_accept;
    logic              w_final;
    logic [ADDR_W-1:0] w_aligned;
    logic [DATA_W-1:0] w_beat0;
    logic [BYTES-1:0]  w_be_lo;
    logic [BYTES-1:0]  w_be_hi;
    logic [DATA_W-1:0] w_wd_lo;
    logic [DATA_W-1:0] w_wd_hi;
    logic [DATA_W-1:0] w_load;

    assign w_req_size  = size_bytes(req_funct3);
    assign w_req_off   = req_addr[OFF_W-1:0];
    assign w_req_cross = (5'(w_req_off) + 5'(w_req_size)) > 5'(BYTES);

    // Classify the incoming request; an illegal one never reaches memory.
    always_comb begin
        w_req_illegal = 1'b0;
        if (req_read && req_write)                       w_req_illegal = 1'b1;
        if (w_req_size > 4'(BYTES))                      w_req_illegal = 1'b1;
        if (req_write && req_funct3[2])                  w_req_illegal = 1'b1;
        if (req_read && (DATA_W == 32) &&
            ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)))
                                                         w_req_illegal = 1'b1;
        if (w_req_cross && (ALLOW_MISALIGNED == 0))      w_req_illegal = 1'b1;
    end

    assign w_accept  = (r_state == MAU_IDLE) && req_valid && (req_read || req_write);
    assign w_final   = mem_resp && (((r_state == MAU_BEAT0) && !r_cross) ||
                                    (r_state == MAU_BEAT1));
    assign w_aligned = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    // During BEAT0 the first beat is still on the bus; afterwards it comes from its register.
    assign w_beat0   = (r_state == MAU_BEAT0) ? mem_rdata : r_rdata0;

    mau_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_funct3 (r_funct3),
        .i_off    (r_addr[OFF_W-1:0]),
        .i_wdata  (r_wdata),
        .i_beat0  (w_beat0),
        .i_beat1  (mem_rdata),
        .o_be_lo  (w_be_lo),
        .o_be_hi  (w_be_hi),
        .o_wd_lo  (w_wd_lo),
        .o_wd_hi  (w_wd_hi),
        .o_rdata  (w_load)
    );

    // Next-state logic for the request/beat/response sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MAU_IDLE:  if (w_accept) w_next = w_req_illegal ? MAU_RESP : MAU_BEAT0;
            MAU_BEAT0: if (mem_resp) w_next = r_cross ? MAU_BEAT1 : MAU_RESP;
            MAU_BEAT1: if (mem_resp) w_next = MAU_RESP;
            MAU_RESP:  w_next = MAU_IDLE;
            default:   w_next = MAU_IDLE;
        endcase
    end

    // State and control flags; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MAU_IDLE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_cross <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_read  <= req_read;
                r_write <= req_write;
                r_err   <= w_req_illegal;
                r_cross <= w_req_cross;
            end
        end
    end

    // Request payload, beat-0 read data and final response data.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
        end
        if ((r_state == MAU_BEAT0) && mem_resp) begin
            r_rdata0 <= mem_rdata;
        end
        if (w_final) begin
            r_rdata <= r_read ? w_load : '0;
        end
    end

    // Output decode purely from registered state, so strobes never glitch on inputs.
    always_comb begin
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_err        = 1'b0;
        resp_rdata      = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        case (r_state)
            MAU_IDLE: begin
                req_ready = 1'b1;
            end
            MAU_BEAT0: begin
                mem_read        = r_read;
                mem_write       = r_write;
                mem_address     = w_aligned;
                mem_byte_enable = w_be_lo;
                mem_wdata       = r_write ? w_wd_lo : '0;
            end
            MAU_BEAT1: begin
                mem_read        = r_read;
                mem_write       = r_write;
                mem_address     = w_aligned + ADDR_W'(BYTES);
                mem_byte_enable = w_be_hi;
                mem_wdata       = r_write ? w_wd_hi : '0;
            end
            MAU_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = r_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized accesses
// checked against a byte-addressed memory reference model.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid_a, req_valid_b, req_read, req_write, mem_resp;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, mem_rdata;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_read, a_mem_write;
    logic [31:0] a_resp_rdata, a_mem_address, a_mem_wdata;
    logic [3:0]  a_mem_byte_enable;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_read, b_mem_write;
    logic [31:0] b_resp_rdata, b_mem_address, b_mem_wdata;
    logic [3:0]  b_mem_byte_enable;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut_a (
        .clk(clk), .rst(rst_n), .req_valid(req_valid_a), .req_ready(a_req_ready),
        .req_read(req_read), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(a_resp_valid),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .mem_read(a_mem_read),
        .mem_write(a_mem_write), .mem_address(a_mem_address), .mem_wdata(a_mem_wdata),
        .mem_byte_enable(a_mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) dut_b (
        .clk(clk), .rst(rst_n), .req_valid(req_valid_b), .req_ready(b_req_ready),
        .req_read(req_read), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(b_resp_valid),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .mem_address(b_mem_address), .mem_wdata(b_mem_wdata),
        .mem_byte_enable(b_mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-addressed memory behind the DUT; untouched bytes have a fixed pattern.
    logic [7:0] dmem [logic [31:0]];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (dmem.exists(a)) return dmem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) dmem[a + 32'(k)] = w[8*k +: 8];
    endtask

    function automatic int model_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3);
        if (rd && wr) return 1'b0;
        if (rd) return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        return f3 inside {3'b000, 3'b001, 3'b010};
    endfunction

    // Load value: size bytes starting at addr, little-endian, then extended.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        logic [31:0] v;
        logic s;
        sz = model_size(f3);
        v  = '0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = rd_byte(addr + 32'(k));
        s = v[8*sz-1];
        for (int b = 8*sz; b < 32; b++) v[b] = f3[2] ? 1'b0 : s;
        return v;
    endfunction

    // Results of the last transaction on DUT A.
    bit          g_seen, g_err, g_extra;
    logic [31:0] g_rdata;
    int          g_nbeats, g_req_cyc, g_lat, g_resp_gap;
    logic [31:0] g_baddr [4];
    logic [3:0]  g_bbe   [4];
    logic [31:0] g_bwd   [4];
    bit          g_bwr   [4];

    // Issue one request to DUT A and act as the memory until the response.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int fixed_wait);
        int guard, cnt, wt, last_resp_cyc;
        guard = 0;
        while (!a_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid_a = 1'b1; req_read = rd; req_write = wr;
        req_funct3 = f3; req_addr = addr; req_wdata = wd;
        g_req_cyc = cyc;
        @(negedge clk);
        req_valid_a = 1'b0; req_read = 1'b0; req_write = 1'b0;
        cnt = 0;
        wt  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(2, 0));
        g_seen = 1'b0; g_extra = 1'b0; g_nbeats = 0; g_err = 1'b0; g_rdata = '0;
        last_resp_cyc = -100;
        for (int i = 0; i < 60 && !g_seen; i++) begin
            mem_resp = 1'b0;
            if (a_resp_valid) begin
                g_seen = 1'b1; g_rdata = a_resp_rdata; g_err = a_resp_err;
                g_lat = cyc - g_req_cyc; g_resp_gap = cyc - last_resp_cyc;
            end else begin
                if (a_mem_read || a_mem_write) begin
                    if (cnt >= wt) begin
                        if (g_nbeats < 4) begin
                            g_baddr[g_nbeats] = a_mem_address;
                            g_bbe[g_nbeats]   = a_mem_byte_enable;
                            g_bwd[g_nbeats]   = a_mem_wdata;
                            g_bwr[g_nbeats]   = a_mem_write;
                        end
                        g_nbeats++;
                        for (int b = 0; b < 4; b++) begin
                            mem_rdata[8*b +: 8] = rd_byte(a_mem_address + 32'(b));
                            if (a_mem_write && a_mem_byte_enable[b])
                                dmem[a_mem_address + 32'(b)] = a_mem_wdata[8*b +: 8];
                        end
                        mem_resp = 1'b1;
                        last_resp_cyc = cyc;
                        cnt = 0;
                        wt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(2, 0));
                    end else begin
                        cnt++;
                    end
                end
                @(negedge clk);
            end
        end
        if (g_seen) begin
            @(negedge clk);
            g_extra = a_resp_valid;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        n_checks++;
        if ({a_req_ready, b_req_ready} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 11", {a_req_ready, b_req_ready});
        end
        n_checks++;
        if ({a_resp_valid, a_resp_err, a_mem_read, a_mem_write} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 0000",
                               {a_resp_valid, a_resp_err, a_mem_read, a_mem_write});
        end
        n_checks++;
        if ({a_resp_rdata, a_mem_address, a_mem_wdata, a_mem_byte_enable} !== 100'd0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h/%b expected zeros",
                               a_resp_rdata, a_mem_address, a_mem_wdata, a_mem_byte_enable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_word;
        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2);
        n_checks++;
        if ({g_seen, g_err, g_nbeats} !== {1'b1, 1'b0, 32'd1}) begin
            n_fail++; $display("FAIL sw_done: seen=%0b err=%0b beats=%0d expected 1/0/1", g_seen, g_err, g_nbeats);
        end
        n_checks++;
        if ({g_baddr[0], g_bbe[0], g_bwd[0], g_bwr[0]} !== {32'h100, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
            n_fail++; $display("FAIL sw_beat: got %h %b %h wr=%0b expected 00000100 1111 deadbeef 1",
                               g_baddr[0], g_bbe[0], g_bwd[0], g_bwr[0]);
        end
        n_checks++;
        if (g_resp_gap !== 1) begin
            n_fail++; $display("FAIL sw_resp_timing: got %0d cycles after mem_resp expected 1", g_resp_gap);
        end
        n_checks++;
        if (model_load(3'b010, 32'h100) !== 32'hDEADBEEF || g_rdata !== 32'h0) begin
            n_fail++; $display("FAIL sw_mem: mem %h rdata %h expected deadbeef 0",
                               model_load(3'b010, 32'h100), g_rdata);
        end
    endtask

    task automatic test_load_extend;
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad  [4] = '{32'h103, 32'h103, 32'h101, 32'h101};
        logic [31:0] pre [4] = '{32'h80112233, 32'h80112233, 32'h00FF8000, 32'h00FF8000};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFF80, 32'h0000FF80};
        for (int i = 0; i < 4; i++) begin
            put_word(32'h100, pre[i]);
            do_access(1'b1, 1'b0, f3[i], ad[i], 32'h0, -1);
            n_checks++;
            if ({g_seen, g_err, g_rdata} !== {1'b1, 1'b0, exp[i]}) begin
                n_fail++; $display("FAIL load_ext[%0d]: got seen=%0b err=%0b %h expected %h",
                                   i, g_seen, g_err, g_rdata, exp[i]);
            end
            n_checks++;
            if ({g_nbeats, g_baddr[0]} !== {32'd1, 32'h100}) begin
                n_fail++; $display("FAIL load_ext_beat[%0d]: got %0d beats at %h expected 1 at 00000100",
                                   i, g_nbeats, g_baddr[0]);
            end
        end
    endtask

    task automatic test_split_store;
        do_access(1'b0, 1'b1, 3'b001, 32'h203, 32'h00001234, -1);
        n_checks++;
        if ({g_seen, g_err, g_nbeats, g_extra} !== {1'b1, 1'b0, 32'd2, 1'b0}) begin
            n_fail++; $display("FAIL sh_split_done: seen=%0b err=%0b beats=%0d extra=%0b expected 1/0/2/0",
                               g_seen, g_err, g_nbeats, g_extra);
        end
        n_checks++;
        if ({g_baddr[0], g_bbe[0], g_bwd[0]} !== {32'h200, 4'b1000, 32'h34000000}) begin
            n_fail++; $display("FAIL sh_beat0: got %h %b %h expected 00000200 1000 34000000",
                               g_baddr[0], g_bbe[0], g_bwd[0]);
        end
        n_checks++;
        if ({g_baddr[1], g_bbe[1], g_bwd[1]} !== {32'h204, 4'b0001, 32'h00000012}) begin
            n_fail++; $display("FAIL sh_beat1: got %h %b %h expected 00000204 0001 00000012",
                               g_baddr[1], g_bbe[1], g_bwd[1]);
        end
    endtask

    task automatic test_split_load;
        logic [31:0] exp;
        put_word(32'h300, 32'hAABBCCDD);
        put_word(32'h304, 32'h11223344);
        do_access(1'b1, 1'b0, 3'b010, 32'h302, 32'h0, -1);
        n_checks++;
        if ({g_seen, g_err, g_rdata} !== {1'b1, 1'b0, 32'h3344AABB}) begin
            n_fail++; $display("FAIL lw_split: got seen=%0b err=%0b %h expected 3344aabb", g_seen, g_err, g_rdata);
        end
        n_checks++;
        if ({g_nbeats, g_baddr[0], g_baddr[1]} !== {32'd2, 32'h300, 32'h304}) begin
            n_fail++; $display("FAIL lw_split_addr: got %0d beats %h %h expected 2 00000300 00000304",
                               g_nbeats, g_baddr[0], g_baddr[1]);
        end
        exp = model_load(3'b010, 32'hFFFFFFFE);
        do_access(1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, -1);
        n_checks++;
        if ({g_nbeats, g_baddr[0], g_baddr[1]} !== {32'd2, 32'hFFFFFFFC, 32'h0}) begin
            n_fail++; $display("FAIL lw_wrap_addr: got %0d beats %h %h expected 2 fffffffc 00000000",
                               g_nbeats, g_baddr[0], g_baddr[1]);
        end
        n_checks++;
        if ({g_seen, g_rdata} !== {1'b1, exp}) begin
            n_fail++; $display("FAIL lw_wrap_data: got %h expected %h", g_rdata, exp);
        end
    endtask

    task automatic test_misaligned_err;
        bit          rd [3] = '{1'b1, 1'b1, 1'b1};
        bit          wr [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [3] = '{3'b010, 3'b010, 3'b011};
        logic [31:0] ad [3] = '{32'h301, 32'h300, 32'h300};
        bit strobe;
        for (int i = 0; i < 3; i++) begin
            req_valid_b = 1'b1; req_read = rd[i]; req_write = wr[i];
            req_funct3 = f3[i]; req_addr = ad[i]; req_wdata = $urandom;
            @(negedge clk);
            req_valid_b = 1'b0; req_read = 1'b0; req_write = 1'b0;
            strobe = b_mem_read | b_mem_write;
            n_checks++;
            if ({b_resp_valid, b_resp_err, b_resp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
                n_fail++; $display("FAIL err_resp[%0d]: got valid=%0b err=%0b rdata=%h expected 1/1/0",
                                   i, b_resp_valid, b_resp_err, b_resp_rdata);
            end
            @(negedge clk);
            strobe = strobe | b_mem_read | b_mem_write;
            n_checks++;
            if ({strobe, b_resp_valid, b_req_ready} !== 3'b001) begin
                n_fail++; $display("FAIL err_after[%0d]: strobe=%0b valid=%0b ready=%0b expected 0/0/1",
                                   i, strobe, b_resp_valid, b_req_ready);
            end
        end
    endtask

    task automatic test_ignore;
        bit bad;
        bad = 1'b0;
        req_valid_a = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = 32'h40;
        repeat (3) begin
            @(negedge clk);
            bad = bad | !a_req_ready | a_mem_read | a_mem_write | a_resp_valid;
        end
        req_valid_a = 1'b0;
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL ignore_noop: activity=%0b expected 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        int c1;
        logic [31:0] wd;
        wd = $urandom;
        do_access(1'b0, 1'b1, 3'b010, 32'h500, wd, 0);
        c1 = g_req_cyc;
        n_checks++;
        if ({g_seen, g_lat} !== {1'b1, 32'd2}) begin
            n_fail++; $display("FAIL b2b_latency: got seen=%0b lat=%0d expected 1/2", g_seen, g_lat);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 0);
        n_checks++;
        if (g_req_cyc - c1 !== 3) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d cycles expected 3", g_req_cyc - c1);
        end
        n_checks++;
        if (g_rdata !== wd) begin
            n_fail++; $display("FAIL b2b_readback: got %h expected %h", g_rdata, wd);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        logic [31:0] wd;
        put_word(32'h300, 32'hAABBCCDD);
        put_word(32'h304, 32'h11223344);
        req_valid_a = 1'b1; req_read = 1'b1; req_write = 1'b0;
        req_funct3 = 3'b010; req_addr = 32'h302;
        @(negedge clk);
        req_valid_a = 1'b0; req_read = 1'b0;
        mem_rdata = 32'hAABBCCDD; mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        n_checks++;
        if ({a_mem_read, a_mem_address} !== {1'b1, 32'h304}) begin
            n_fail++; $display("FAIL rstmid_beat1: got read=%0b addr=%h expected 1 00000304", a_mem_read, a_mem_address);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_mem_read, a_mem_address} !== {1'b0, 32'h0}) begin
            n_fail++; $display("FAIL rstmid_async_drop: got read=%0b addr=%h expected 0 0", a_mem_read, a_mem_address);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | a_resp_valid;
        end
        rst_n = 1'b1;
        n_checks++;
        if ({seen, a_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rstmid_state: resp_seen=%0b ready=%0b expected 0/1", seen, a_req_ready);
        end
        wd = $urandom;
        do_access(1'b0, 1'b1, 3'b010, 32'h100, wd, 1);
        n_checks++;
        if ({g_seen, g_err, g_nbeats, model_load(3'b010, 32'h100)} !== {1'b1, 1'b0, 32'd1, wd}) begin
            n_fail++; $display("FAIL rstmid_followup: seen=%0b err=%0b beats=%0d mem=%h expected 1/0/1/%h",
                               g_seen, g_err, g_nbeats, model_load(3'b010, 32'h100), wd);
        end
    endtask

    task automatic test_random;
        bit          rd, wr, legal;
        int          kind, sz, exp_beats, bad_bytes;
        logic [2:0]  f3;
        logic [31:0] addr, wd, exp_rdata;
        logic [7:0]  snap [10];
        for (int it = 0; it < 60; it++) begin
            kind = int'($urandom_range(9, 0));
            rd = (kind <= 5); wr = (kind == 0) || (kind >= 6);
            f3 = 3'($urandom_range(7, 0));
            addr = ($urandom_range(3, 0) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(7, 0))
                                               : 32'h400 + 32'($urandom_range(63, 0));
            wd = $urandom;
            legal = model_legal(rd, wr, f3);
            sz = model_size(f3);
            exp_beats = !legal ? 0 : ((int'(addr[1:0]) + sz > 4) ? 2 : 1);
            exp_rdata = (legal && rd) ? model_load(f3, addr) : 32'h0;
            for (int k = 0; k < 10; k++) snap[k] = rd_byte(addr - 32'd1 + 32'(k));
            if (legal && wr) for (int k = 0; k < sz; k++) snap[k+1] = wd[8*k +: 8];
            do_access(rd, wr, f3, addr, wd, -1);
            n_checks++;
            if ({g_seen, g_err, g_extra} !== {1'b1, !legal, 1'b0}) begin
                n_fail++; $display("FAIL rand_resp[%0d]: rd=%0b wr=%0b f3=%b addr=%h seen=%0b err=%0b extra=%0b expected err=%0b",
                                   it, rd, wr, f3, addr, g_seen, g_err, g_extra, !legal);
            end
            n_checks++;
            if (g_nbeats !== exp_beats) begin
                n_fail++; $display("FAIL rand_beats[%0d]: addr=%h f3=%b got %0d expected %0d",
                                   it, addr, f3, g_nbeats, exp_beats);
            end
            n_checks++;
            if (g_rdata !== exp_rdata) begin
                n_fail++; $display("FAIL rand_rdata[%0d]: rd=%0b f3=%b addr=%h got %h expected %h",
                                   it, rd, f3, addr, g_rdata, exp_rdata);
            end
            bad_bytes = 0;
            for (int k = 0; k < 10; k++) if (rd_byte(addr - 32'd1 + 32'(k)) !== snap[k]) bad_bytes++;
            n_checks++;
            if (bad_bytes !== 0) begin
                n_fail++; $display("FAIL rand_mem[%0d]: wr=%0b f3=%b addr=%h wd=%h got %0d wrong bytes expected 0",
                                   it, wr, f3, addr, wd, bad_bytes);
            end
        end
    endtask

    initial begin
        req_valid_a = 1'b0; req_valid_b = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
        test_reset;
        test_store_word;
        test_load_extend;
        test_split_store;
        test_split_load;
        test_misaligned_err;
        test_ignore;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
